// File: rtl/alu_op_sequencer_if.sv
// Decode request / result bundle between the controller and the ALU op sequencer.
interface alu_op_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       is_imm;
  logic       flush;
  logic       out_valid;
  logic [4:0] Operation;
  logic       is_multi;
  logic       illegal;
  logic       stall;

  modport master (
    output in_valid, ALUOp, Funct3, Funct7, is_imm, flush,
    input  in_ready, out_valid, Operation, is_multi, illegal, stall
  );

  modport slave (
    input  in_valid, ALUOp, Funct3, Funct7, is_imm, flush,
    output in_ready, out_valid, Operation, is_multi, illegal, stall
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered ALU operation decoder. Single-cycle ops complete the cycle after
// accept; RV32M mul/div ops hold the sequencer busy (stall) for their latency.
module alu_op_sequencer #(
  parameter int unsigned ENABLE_M = 1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BLT  = 5'b01010;
  localparam logic [4:0] OP_BGE  = 5'b01011;
  localparam logic [4:0] OP_SLT  = 5'b01100;
  localparam logic [4:0] OP_SLTU = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;
  localparam logic [4:0] OP_LUI  = 5'b11111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Counter preload: BUSY lasts LAT-1 cycles, the final one at cnt==0.
  localparam int unsigned MUL_LD = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int unsigned DIV_LD = (DIV_LAT > 1) ? DIV_LAT - 2 : 0;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {K_SINGLE, K_MUL, K_DIV} kind_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic [4:0]       op_q;
  logic             multi_q;
  logic             illegal_q;
  logic             stall_q;

  logic [4:0]       dec_op;
  logic             dec_ill;
  kind_t            dec_kind;
  logic             dec_one;
  logic [CNT_W-1:0] dec_load;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      3'b000:  r = OP_ADD;
      3'b001:  r = OP_SLL;
      3'b010:  r = OP_SLT;
      3'b011:  r = OP_SLTU;
      3'b100:  r = OP_XOR;
      3'b101:  r = OP_SRL;
      3'b110:  r = OP_OR;
      default: r = OP_AND;
    endcase
    return r;
  endfunction

  // Decode the presented request into operation code, illegal flag and op class.
  always_comb begin
    dec_op   = OP_ADD;
    dec_ill  = 1'b0;
    dec_kind = K_SINGLE;
    case (bus.ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b11: dec_op = OP_LUI;
      2'b01: begin
        case (bus.Funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        if (bus.is_imm) begin
          if (bus.Funct3 == 3'b001) begin
            if (bus.Funct7 == F7_BASE) dec_op = OP_SLL;
            else                       dec_ill = 1'b1;
          end else if (bus.Funct3 == 3'b101) begin
            if (bus.Funct7 == F7_BASE)     dec_op = OP_SRL;
            else if (bus.Funct7 == F7_ALT) dec_op = OP_SRA;
            else                           dec_ill = 1'b1;
          end else begin
            dec_op = base_op(bus.Funct3);
          end
        end else begin
          case (bus.Funct7)
            F7_BASE: dec_op = base_op(bus.Funct3);
            F7_ALT: begin
              if (bus.Funct3 == 3'b000)      dec_op = OP_SUB;
              else if (bus.Funct3 == 3'b101) dec_op = OP_SRA;
              else                           dec_ill = 1'b1;
            end
            F7_MULDIV: begin
              if (ENABLE_M != 0) begin
                dec_op   = {2'b10, bus.Funct3};
                dec_kind = bus.Funct3[2] ? K_DIV : K_MUL;
              end else begin
                dec_ill = 1'b1;
              end
            end
            default: dec_ill = 1'b1;
          endcase
        end
      end
    endcase
    if (dec_ill) begin
      dec_op   = OP_ADD;
      dec_kind = K_SINGLE;
    end
  end

  // Choose single-cycle completion vs busy countdown for the decoded class.
  always_comb begin
    dec_one  = 1'b1;
    dec_load = '0;
    case (dec_kind)
      K_MUL: begin
        dec_one  = (MUL_LAT == 1);
        dec_load = CNT_W'(MUL_LD);
      end
      K_DIV: begin
        dec_one  = (DIV_LAT == 1);
        dec_load = CNT_W'(DIV_LD);
      end
      default: begin
        dec_one  = 1'b1;
        dec_load = '0;
      end
    endcase
  end

  // IDLE/BUSY sequencer; flush overrides accept and completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      multi_q     <= 1'b0;
      illegal_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q      <= dec_op;
            illegal_q <= dec_ill;
            multi_q   <= (dec_kind != K_SINGLE);
            if (dec_one) begin
              out_valid_q <= 1'b1;
            end else begin
              cnt     <= dec_load;
              state   <= BUSY;
              stall_q <= 1'b1;
            end
          end
        end
        default: begin
          if (cnt == '0) begin
            state       <= IDLE;
            out_valid_q <= 1'b1;
            stall_q     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !bus.flush;
  assign bus.out_valid = out_valid_q;
  assign bus.Operation = op_q;
  assign bus.is_multi  = multi_q;
  assign bus.illegal   = illegal_q;
  assign bus.stall     = stall_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: three parameterisations driven by one stimulus
// stream, each compared every cycle against a latency-schedule reference model.
module tb_alu_op_sequencer;

  localparam int ND = 3;
  localparam int P_EN[ND]   = '{1, 1, 0};
  localparam int P_MLAT[ND] = '{3, 1, 3};
  localparam int P_DLAT[ND] = '{8, 2, 8};

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [1:0] aluop;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_imm;
  logic       flush;

  alu_op_sequencer_if b0 ();
  alu_op_sequencer_if b1 ();
  alu_op_sequencer_if b2 ();

  alu_op_sequencer #(.ENABLE_M(1), .MUL_LAT(3), .DIV_LAT(8), .CNT_W(4))
    dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  alu_op_sequencer #(.ENABLE_M(1), .MUL_LAT(1), .DIV_LAT(2), .CNT_W(4))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  alu_op_sequencer #(.ENABLE_M(0), .MUL_LAT(3), .DIV_LAT(8), .CNT_W(4))
    dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  assign b0.in_valid = in_valid; assign b1.in_valid = in_valid; assign b2.in_valid = in_valid;
  assign b0.ALUOp    = aluop;    assign b1.ALUOp    = aluop;    assign b2.ALUOp    = aluop;
  assign b0.Funct3   = f3;       assign b1.Funct3   = f3;       assign b2.Funct3   = f3;
  assign b0.Funct7   = f7;       assign b1.Funct7   = f7;       assign b2.Funct7   = f7;
  assign b0.is_imm   = is_imm;   assign b1.is_imm   = is_imm;   assign b2.is_imm   = is_imm;
  assign b0.flush    = flush;    assign b1.flush    = flush;    assign b2.flush    = flush;

  logic       o_ready[ND];
  logic       o_valid[ND];
  logic [4:0] o_op[ND];
  logic       o_multi[ND];
  logic       o_ill[ND];
  logic       o_stall[ND];

  assign o_ready[0] = b0.in_ready;  assign o_ready[1] = b1.in_ready;  assign o_ready[2] = b2.in_ready;
  assign o_valid[0] = b0.out_valid; assign o_valid[1] = b1.out_valid; assign o_valid[2] = b2.out_valid;
  assign o_op[0]    = b0.Operation; assign o_op[1]    = b1.Operation; assign o_op[2]    = b2.Operation;
  assign o_multi[0] = b0.is_multi;  assign o_multi[1] = b1.is_multi;  assign o_multi[2] = b2.is_multi;
  assign o_ill[0]   = b0.illegal;   assign o_ill[1]   = b1.illegal;   assign o_ill[2]   = b2.illegal;
  assign o_stall[0] = b0.stall;     assign o_stall[1] = b1.stall;     assign o_stall[2] = b2.stall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected outputs plus the cycle index at which each
  // instance becomes free again (accept cycle + latency).
  int n;
  int busy_until[ND];
  bit ev[ND];
  int eop[ND];
  bit eill[ND];
  bit emul[ND];
  bit estall[ND];

  int alu_tab[8] = '{2, 6, 12, 13, 4, 5, 1, 0};
  int br_tab[8]  = '{8, 9, -1, -1, 10, 11, 14, 15};

  // kind: 0 single-cycle, 1 multiply, 2 divide
  task automatic ref_decode(input int en, input logic [1:0] a, input logic [2:0] x3,
                            input logic [6:0] x7, input logic im,
                            output int op, output bit ill, output int kind);
    int f3i, f7i;
    f3i  = int'(x3);
    f7i  = int'(x7);
    ill  = 0;
    kind = 0;
    op   = 2;
    if (a == 2'd0) op = 2;
    else if (a == 2'd3) op = 31;
    else if (a == 2'd1) begin
      op = br_tab[f3i];
      if (op < 0) ill = 1;
    end else if (f7i == 1 && !im) begin
      if (en != 0) begin
        op   = 16 + f3i;
        kind = (f3i >= 4) ? 2 : 1;
      end else ill = 1;
    end else if (im) begin
      if (f3i == 1 && f7i != 0) ill = 1;
      else if (f3i == 5 && f7i != 0 && f7i != 32) ill = 1;
      else op = (f3i == 5 && f7i == 32) ? 7 : alu_tab[f3i];
    end else if (f7i == 0) op = alu_tab[f3i];
    else if (f7i == 32) begin
      if (f3i == 0) op = 3;
      else if (f3i == 5) op = 7;
      else ill = 1;
    end else ill = 1;
    if (ill) begin
      op   = 2;
      kind = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      busy_until[d] = 0;
      ev[d] = 0; eop[d] = 0; eill[d] = 0; emul[d] = 0; estall[d] = 0;
    end
  endtask

  // One clock cycle: check registered outputs, apply inputs, check in_ready,
  // advance the model across the coming rising edge.
  task automatic step(input logic v, input logic [1:0] a, input logic [2:0] x3,
                      input logic [6:0] x7, input logic im, input logic fl);
    int op, kind, lat;
    bit ill, idle;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d.out_valid", d), 32'(o_valid[d]), 32'(ev[d]));
      check($sformatf("d%0d.Operation", d), 32'(o_op[d]),    32'(eop[d]));
      check($sformatf("d%0d.illegal", d),   32'(o_ill[d]),   32'(eill[d]));
      check($sformatf("d%0d.is_multi", d),  32'(o_multi[d]), 32'(emul[d]));
      check($sformatf("d%0d.stall", d),     32'(o_stall[d]), 32'(estall[d]));
    end
    in_valid = v; aluop = a; f3 = x3; f7 = x7; is_imm = im; flush = fl;
    #1;
    for (int d = 0; d < ND; d++) begin
      idle = (n >= busy_until[d]);
      check($sformatf("d%0d.in_ready", d), 32'(o_ready[d]), 32'(idle && !fl));
      if (fl) begin
        busy_until[d] = n + 1;
        ev[d] = 0;
        estall[d] = 0;
      end else if (idle && v) begin
        ref_decode(P_EN[d], a, x3, x7, im, op, ill, kind);
        lat = (kind == 0) ? 1 : (kind == 1) ? P_MLAT[d] : P_DLAT[d];
        eop[d] = op; eill[d] = ill; emul[d] = (kind != 0);
        busy_until[d] = n + lat;
        ev[d] = (lat == 1);
        estall[d] = (lat > 1);
      end else begin
        ev[d] = (busy_until[d] == n + 1) && !idle;
        estall[d] = (n + 1 < busy_until[d]);
      end
    end
    n++;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 2'b00, 3'b000, 7'b0, 1'b0, 1'b0);
  endtask

  logic [6:0] rf7;

  initial begin
    n = 0;
    model_reset();
    reset = 1'b1;
    in_valid = 1'b0; aluop = '0; f3 = '0; f7 = '0; is_imm = 1'b0; flush = 1'b0;
    #12;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d.rst_valid", d), 32'(o_valid[d]), 32'd0);
      check($sformatf("d%0d.rst_op", d),    32'(o_op[d]),    32'd0);
      check($sformatf("d%0d.rst_stall", d), 32'(o_stall[d]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // SUB vs ADDI with the same Funct7
    step(1'b1, 2'b10, 3'b000, 7'b0100000, 1'b0, 1'b0);
    step(1'b1, 2'b10, 3'b000, 7'b0100000, 1'b1, 1'b0);
    // back-to-back ADD, OR, SRA, LUI
    step(1'b1, 2'b00, 3'b000, 7'b0000000, 1'b0, 1'b0);
    step(1'b1, 2'b10, 3'b110, 7'b0000000, 1'b0, 1'b0);
    step(1'b1, 2'b10, 3'b101, 7'b0100000, 1'b0, 1'b0);
    step(1'b1, 2'b11, 3'b000, 7'b0000000, 1'b0, 1'b0);
    idle_cycles(1);
    // DIVU full latency
    step(1'b1, 2'b10, 3'b101, 7'b0000001, 1'b0, 1'b0);
    idle_cycles(9);
    // MUL, flush on the second cycle after accept, then ADD
    step(1'b1, 2'b10, 3'b000, 7'b0000001, 1'b0, 1'b0);
    idle_cycles(1);
    step(1'b0, 2'b00, 3'b000, 7'b0000000, 1'b0, 1'b1);
    step(1'b1, 2'b10, 3'b000, 7'b0000000, 1'b0, 1'b0);
    idle_cycles(4);
    // illegal branch funct3, illegal Funct7, illegal shift-immediate
    step(1'b1, 2'b01, 3'b010, 7'b0000000, 1'b0, 1'b0);
    step(1'b1, 2'b10, 3'b000, 7'b1111111, 1'b0, 1'b0);
    step(1'b1, 2'b10, 3'b001, 7'b0100000, 1'b1, 1'b0);
    idle_cycles(1);

    // asynchronous reset in the middle of a divide
    step(1'b1, 2'b10, 3'b100, 7'b0000001, 1'b0, 1'b0);
    idle_cycles(3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d.arst_valid", d), 32'(o_valid[d]), 32'd0);
      check($sformatf("d%0d.arst_op", d),    32'(o_op[d]),    32'd0);
      check($sformatf("d%0d.arst_multi", d), 32'(o_multi[d]), 32'd0);
      check($sformatf("d%0d.arst_ill", d),   32'(o_ill[d]),   32'd0);
      check($sformatf("d%0d.arst_stall", d), 32'(o_stall[d]), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    reset = 1'b0;
    model_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       rf7 = 7'b0000000;
        1:       rf7 = 7'b0100000;
        2, 3:    rf7 = 7'b0000001;
        default: rf7 = 7'($urandom);
      endcase
      step(($urandom_range(0, 9) < 7), 2'($urandom), 3'($urandom), rf7,
           1'($urandom), ($urandom_range(0, 99) < 5));
    end
    idle_cycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
